ysyx_22040759_mem_arbiter: RTL and testbench
============================================

# ysyx_22040759_mem_arbiter

N-channel arbiter that merges several core-side memory request ports (instruction-cache refill, load/store unit, future D-cache/DMA) onto the single valid/ready memory port feeding the AXI bridge. It replaces the fixed two-port wiring of the current core with a parametrised, registered, one-outstanding-transaction arbiter. It uses round-robin or fixed-priority selection.

## Interface
Parameters:
- N_CH, 2: number of requesting channels, 2..8.
- ADDR_W, 64: address width.
- DATA_W, 64: read/write data width.

Ports:
- clock  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ch_valid  in  N_CH  per-channel request valid.
- ch_req  in  N_CH  per-channel direction, 1 = write, 0 = read.
- ch_addr  in  N_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  N_CH*DATA_W  packed write data.
- ch_size  in  N_CH*3  packed access size, same encoding as the memory port (0=B, 1=H, 2=W, 3=D).
- ch_ready  out  N_CH  one-cycle completion pulse to the granted channel.
- ch_rdata  out  DATA_W  read data, shared by all channels, valid with ch_ready.
- mem_valid  out  1  downstream request valid.
- mem_ready  in  1  downstream completion pulse.
- mem_req  out  1  downstream direction.
- mem_addr  out  ADDR_W  downstream address.
- mem_data_write  out  DATA_W  downstream write data.
- mem_size  out  3  downstream size.
- mem_data_read  in  DATA_W  downstream read data, valid with mem_ready.
- grant_id  out  $clog2(N_CH)  index of current/last granted channel (debug, difftest).

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any ch_valid is set, pick a winner and latch its req, addr, wdata and size into output registers.
  - Set mem_valid and go to BUSY.
  - With no valid, stay in IDLE.
- **BUSY**
  - Hold all mem_* outputs stable.
  - On mem_ready, latch mem_data_read into ch_rdata and go to RESP.
  - Winner's ch_valid deasserting in BUSY is ignored; the transaction completes and its ready is still issued.
- **RESP**
  - ch_ready[grant_id] = 1 for exactly this cycle; mem_valid = 0.
  - Advance the priority pointer and go to IDLE.
- **Channel rule:** a channel deasserts ch_valid in the cycle after its ch_ready. If ch_valid is still high in IDLE, that is a new request.
- mem_ready outside BUSY is ignored.
- Only one transaction is outstanding; there is no pipelining of requests.
- ch_rdata holds its last value until the next read completes. It is undefined for writes but must not change on writes.
- **Reset**, asynchronous, also mid-transaction:
  - state = IDLE, mem_valid = 0, ch_ready = 0.
  - mem_req, mem_addr, mem_data_write, mem_size and ch_rdata = 0.
  - grant_id = 0, pointer = 0.
  - Any in-flight downstream transaction is abandoned.

## Timing
- Request seen in IDLE at cycle t: mem_valid is high from t+1.
- mem_ready at cycle d: ch_ready and ch_rdata at d+1, IDLE at d+2, next grant visible on mem_valid at d+3.
- Minimum request-to-ready latency is 3 cycles when mem_ready arrives in the first BUSY cycle.
- All outputs are registered; there is no combinational path from ch_* or mem_ready to any output.

## Configuration
- YSYX_22040759_ARB_RR_EN **defined**: round-robin selection.
  - The pointer starts at 0.
  - After each completion, pointer = (grant_id + 1) mod N_CH.
  - The winner is the first valid channel at or after the pointer, wrapping.
- YSYX_22040759_ARB_RR_EN **undefined**: fixed priority.
  - The lowest-index valid channel wins.
  - The pointer register is not instantiated.

## Structure
- Package ysyx_22040759_arb_pkg holds:
  - the state enum (IDLE/BUSY/RESP);
  - size encodings MEM_SIZE_B/H/W/D;
  - localparam N_CH_MAX = 8.
- One sub-module, ysyx_22040759_rr_pick: combinational picker.
  - Inputs: request mask and start pointer.
  - Outputs: one-hot grant and index.
  - Fixed priority is the same module with the pointer tied to 0.

## Test plan
- **Single read:** N_CH=2, ch0 read addr 0x8000_0000 size 3; mem_ready one cycle after mem_valid with data 0xDEAD_BEEF_0123_4567 -> ch_ready=2'b01 one cycle, ch_rdata equals that value, 3-cycle latency.
- **Contention, RR on:** ch0 and ch1 held valid continuously -> grants alternate 0,1,0,1 over four transactions.
- **Contention, RR off:** same stimulus -> ch0 always granted while valid; ch1 granted only after ch0 drops.
- **Wrap, N_CH=4, RR on:** pointer at 3, channels 1 and 3 valid -> 3 wins; next with only 1 valid -> 1 wins.
- **Write stability:** ch1 write addr 0x8000_1000 wdata 0x55 size 0; mem_ready withheld 10 cycles -> mem_* stable throughout, ch_rdata unchanged, single ch_ready pulse.
- **Reset mid-BUSY:** assert reset during BUSY -> mem_valid and ch_ready fall immediately; after release, IDLE with grant_id=0 and a stale mem_ready ignored.

Source files
------------

// File: rtl/ysyx_22040759_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// memory-port size codes and the channel-count ceiling.
package ysyx_22040759_arb_pkg;

  localparam int N_CH_MAX = 8;

  localparam logic [2:0] MEM_SIZE_B = 3'd0;
  localparam logic [2:0] MEM_SIZE_H = 3'd1;
  localparam logic [2:0] MEM_SIZE_W = 3'd2;
  localparam logic [2:0] MEM_SIZE_D = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ysyx_22040759_rr_pick.sv
// Combinational picker: grants the first requesting channel at or after the
// start pointer, wrapping. With the pointer tied to 0 it is fixed priority.
module ysyx_22040759_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      idx = IDX_W'(j);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/ysyx_22040759_mem_arbiter.sv
// N-channel, one-outstanding-transaction memory arbiter with registered outputs.
// YSYX_22040759_ARB_RR_EN selects round-robin; undefined gives fixed priority.
module ysyx_22040759_mem_arbiter
  import ysyx_22040759_arb_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_wdata,
  input  logic [N_CH*3-1:0]        ch_size,
  output logic [N_CH-1:0]          ch_ready,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data_write,
  output logic [2:0]               mem_size,
  input  logic [DATA_W-1:0]        mem_data_read,
  output logic [$clog2(N_CH)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(N_CH);

  arb_state_e        state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_size_q, mem_size_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_CH-1:0]   ready_q, ready_d;
  logic [IDX_W-1:0]  grant_q, grant_d;

  logic [IDX_W-1:0]  pick_ptr;
  logic [N_CH-1:0]   pick_oh;
  logic [IDX_W-1:0]  pick_idx;

  ysyx_22040759_rr_pick #(.N(N_CH), .IDX_W(IDX_W)) u_pick (
    .req_i     (ch_valid),
    .ptr_i     (pick_ptr),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

`ifdef YSYX_22040759_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Pointer moves past the channel just served, so it loses priority next round.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP)
      ptr_d = (grant_q == IDX_W'(N_CH - 1)) ? '0 : grant_q + IDX_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    rdata_d     = rdata_q;
    grant_d     = grant_q;
    ready_d     = '0;
    case (state_q)
      IDLE: begin
        if (|pick_oh) begin
          state_d     = BUSY;
          mem_valid_d = 1'b1;
          grant_d     = pick_idx;
          mem_req_d   = ch_req[pick_idx];
          mem_addr_d  = ch_addr[pick_idx*ADDR_W +: ADDR_W];
          mem_wdata_d = ch_wdata[pick_idx*DATA_W +: DATA_W];
          mem_size_d  = ch_size[pick_idx*3 +: 3];
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d          = RESP;
          mem_valid_d      = 1'b0;
          ready_d[grant_q] = 1'b1;
          // Writes leave the last read data untouched.
          if (!mem_req_q) rdata_d = mem_data_read;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      rdata_q     <= '0;
      ready_q     <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      grant_q     <= grant_d;
    end
  end

  assign ch_ready       = ready_q;
  assign ch_rdata       = rdata_q;
  assign mem_valid      = mem_valid_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data_write = mem_wdata_q;
  assign mem_size       = mem_size_q;
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Directed bench for the memory arbiter: a 2-channel and a 4-channel instance,
// expectations follow YSYX_22040759_ARB_RR_EN when it is defined.
module tb_ysyx_22040759_mem_arbiter;
  import ysyx_22040759_arb_pkg::*;

`ifdef YSYX_22040759_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [63:0] last_rd;

  always #5 clock = ~clock;

  // 2-channel instance
  logic [1:0]   a_valid, a_req, a_ready;
  logic [127:0] a_addr, a_wdata;
  logic [5:0]   a_size;
  logic [63:0]  a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic         a_mvalid, a_mready, a_mreq;
  logic [2:0]   a_msize;
  logic [0:0]   a_gid;

  // 4-channel instance
  logic [3:0]   b_valid, b_req, b_ready;
  logic [255:0] b_addr, b_wdata;
  logic [11:0]  b_size;
  logic [63:0]  b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic         b_mvalid, b_mready, b_mreq;
  logic [2:0]   b_msize;
  logic [1:0]   b_gid;

  ysyx_22040759_mem_arbiter #(.N_CH(2), .ADDR_W(64), .DATA_W(64)) u_dut2 (
    .clock(clock), .reset(reset), .ch_valid(a_valid), .ch_req(a_req),
    .ch_addr(a_addr), .ch_wdata(a_wdata), .ch_size(a_size), .ch_ready(a_ready),
    .ch_rdata(a_rdata), .mem_valid(a_mvalid), .mem_ready(a_mready), .mem_req(a_mreq),
    .mem_addr(a_maddr), .mem_data_write(a_mwdata), .mem_size(a_msize),
    .mem_data_read(a_mrdata), .grant_id(a_gid)
  );

  ysyx_22040759_mem_arbiter #(.N_CH(4), .ADDR_W(64), .DATA_W(64)) u_dut4 (
    .clock(clock), .reset(reset), .ch_valid(b_valid), .ch_req(b_req),
    .ch_addr(b_addr), .ch_wdata(b_wdata), .ch_size(b_size), .ch_ready(b_ready),
    .ch_rdata(b_rdata), .mem_valid(b_mvalid), .mem_ready(b_mready), .mem_req(b_mreq),
    .mem_addr(b_maddr), .mem_data_write(b_mwdata), .mem_size(b_msize),
    .mem_data_read(b_mrdata), .grant_id(b_gid)
  );

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Drives a request set, waits for the grant, completes it with one mem_ready pulse.
  task automatic txn2(input logic [1:0] vld, input logic [63:0] rd, output logic [0:0] gid,
                      output logic [63:0] addr, output logic [1:0] rdy, output int wc,
                      output bit to);
    a_valid = vld; to = 1'b1; gid = '0; addr = '0; rdy = '0; wc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (a_mvalid) begin to = 1'b0; wc = i + 1; break; end
    end
    if (!to) begin
      gid = a_gid; addr = a_maddr;
      a_mrdata = rd; a_mready = 1'b1;
      @(posedge clock); #1;
      a_mready = 1'b0;
      rdy = a_ready;
    end
  endtask

  task automatic txn4(input logic [3:0] vld, output logic [1:0] gid, output logic [63:0] addr,
                      output logic [3:0] rdy, output bit to);
    b_valid = vld; to = 1'b1; gid = '0; addr = '0; rdy = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (b_mvalid) begin to = 1'b0; break; end
    end
    if (!to) begin
      gid = b_gid; addr = b_maddr;
      b_mrdata = 64'h4444; b_mready = 1'b1;
      @(posedge clock); #1;
      b_mready = 1'b0;
      rdy = b_ready;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({a_mvalid, a_ready, a_gid, a_mreq} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl2 got=%0h exp=0", {a_mvalid, a_ready, a_gid, a_mreq});
    end
    checks++;
    if ({a_maddr, a_mwdata, a_msize, a_rdata} !== '0) begin
      failures++; $display("FAIL reset_data2 got addr=%0h wdata=%0h size=%0h rdata=%0h exp=0",
                           a_maddr, a_mwdata, a_msize, a_rdata);
    end
    checks++;
    if ({b_mvalid, b_ready, b_gid} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl4 got=%0h exp=0", {b_mvalid, b_ready, b_gid});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    logic [0:0] gid; logic [63:0] addr; logic [1:0] rdy; int wc; bit to;
    a_req = 2'b00; a_addr[63:0] = 64'h8000_0000; a_size[2:0] = MEM_SIZE_D;
    txn2(2'b01, 64'hDEAD_BEEF_0123_4567, gid, addr, rdy, wc, to);
    checks++;
    if (to || wc != 1) begin
      failures++; $display("FAIL single_valid_latency got=%0d timeout=%0d exp=1", wc, to);
    end
    checks++;
    if (gid !== 1'b0 || addr !== 64'h8000_0000) begin
      failures++; $display("FAIL single_grant got gid=%0h addr=%0h exp gid=0 addr=80000000", gid, addr);
    end
    checks++;
    if (rdy !== 2'b01 || a_rdata !== 64'hDEAD_BEEF_0123_4567 || a_mvalid !== 1'b0) begin
      failures++; $display("FAIL single_ready got rdy=%0h rdata=%0h mvalid=%0h exp rdy=1 rdata=deadbeef01234567 mvalid=0",
                           rdy, a_rdata, a_mvalid);
    end
    a_valid = 2'b00;
    @(posedge clock); #1;
    checks++;
    if (a_ready !== 2'b00 || a_mvalid !== 1'b0 || a_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      failures++; $display("FAIL single_after got rdy=%0h mvalid=%0h rdata=%0h exp 0 0 deadbeef01234567",
                           a_ready, a_mvalid, a_rdata);
    end
  endtask

  task automatic test_contention();
    logic [0:0] gid; logic [63:0] addr; logic [1:0] rdy; int wc; bit to;
    logic [0:0] exp;
    do_reset();
    a_addr = {64'h2000, 64'h1000}; a_req = 2'b00; a_size = {MEM_SIZE_D, MEM_SIZE_D};
    for (int k = 0; k < 4; k++) begin
      exp = RR ? 1'(k % 2) : 1'b0;
      txn2(2'b11, 64'hA0 + 64'(k), gid, addr, rdy, wc, to);
      checks++;
      if (to || gid !== exp || rdy !== (2'b01 << exp) || a_rdata !== 64'hA0 + 64'(k)) begin
        failures++; $display("FAIL contention_%0d got gid=%0h rdy=%0h rdata=%0h to=%0d exp gid=%0h rdy=%0h rdata=%0h",
                             k, gid, rdy, a_rdata, to, exp, 2'b01 << exp, 64'hA0 + 64'(k));
      end
    end
    txn2(2'b10, 64'hB0, gid, addr, rdy, wc, to);
    a_valid = 2'b00;
    last_rd = 64'hB0;
    checks++;
    if (to || gid !== 1'b1 || addr !== 64'h2000 || rdy !== 2'b10) begin
      failures++; $display("FAIL contention_ch1_only got gid=%0h addr=%0h rdy=%0h to=%0d exp 1 2000 2",
                           gid, addr, rdy, to);
    end
  endtask

  task automatic test_write_stability();
    logic [211:0] exp_v;
    a_addr[127:64] = 64'h8000_1000; a_wdata[127:64] = 64'h55; a_size[5:3] = MEM_SIZE_B;
    a_req = 2'b10; a_valid = 2'b10; a_mrdata = '1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    exp_v = {1'b1, 1'b1, 64'h8000_1000, 64'h55, 3'd0, 2'b00, last_rd, 1'b1};
    for (int c = 0; c < 10; c++) begin
      if (c == 2) a_valid = 2'b00;
      checks++;
      if ({a_mvalid, a_mreq, a_maddr, a_mwdata, a_msize, a_ready, a_rdata, a_gid} !== exp_v) begin
        failures++; $display("FAIL write_hold_%0d got v=%0h req=%0h addr=%0h wd=%0h sz=%0h rdy=%0h rd=%0h gid=%0h exp v=1 req=1 addr=80001000 wd=55 sz=0 rdy=0 rd=%0h gid=1",
                             c, a_mvalid, a_mreq, a_maddr, a_mwdata, a_msize, a_ready, a_rdata, a_gid, last_rd);
      end
      @(posedge clock); #1;
    end
    a_mready = 1'b1;
    @(posedge clock); #1;
    a_mready = 1'b0;
    checks++;
    if (a_ready !== 2'b10 || a_rdata !== last_rd) begin
      failures++; $display("FAIL write_ready got rdy=%0h rdata=%0h exp rdy=2 rdata=%0h", a_ready, a_rdata, last_rd);
    end
    @(posedge clock); #1;
    checks++;
    if (a_ready !== 2'b00 || a_mvalid !== 1'b0) begin
      failures++; $display("FAIL write_single_pulse got rdy=%0h mvalid=%0h exp 0 0", a_ready, a_mvalid);
    end
    a_mready = 1'b1;
    @(posedge clock); #1;
    a_mready = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (a_ready !== 2'b00 || a_mvalid !== 1'b0 || a_rdata !== last_rd) begin
      failures++; $display("FAIL idle_mem_ready got rdy=%0h mvalid=%0h rdata=%0h exp 0 0 %0h",
                           a_ready, a_mvalid, a_rdata, last_rd);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [0:0] gid; logic [63:0] addr; logic [1:0] rdy; int wc; bit to;
    a_req = 2'b00; a_valid = 2'b10;
    @(posedge clock); #1;
    checks++;
    if (a_mvalid !== 1'b1 || a_gid !== 1'b1) begin
      failures++; $display("FAIL rst_busy_pre got mvalid=%0h gid=%0h exp 1 1", a_mvalid, a_gid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_mvalid, a_ready, a_gid} !== 4'b0 || a_maddr !== '0 || a_rdata !== '0) begin
      failures++; $display("FAIL rst_async got mvalid=%0h rdy=%0h gid=%0h addr=%0h rdata=%0h exp all 0",
                           a_mvalid, a_ready, a_gid, a_maddr, a_rdata);
    end
    a_valid = 2'b00;
    @(posedge clock); #1;
    reset = 1'b0;
    a_mready = 1'b1;
    @(posedge clock); #1;
    a_mready = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({a_mvalid, a_ready, a_gid} !== 4'b0) begin
      failures++; $display("FAIL rst_stale_ready got mvalid=%0h rdy=%0h gid=%0h exp 0 0 0", a_mvalid, a_ready, a_gid);
    end
    a_mrdata = '0;
    txn2(2'b01, 64'h77, gid, addr, rdy, wc, to);
    a_valid = 2'b00;
    checks++;
    if (to || wc != 1 || gid !== 1'b0 || rdy !== 2'b01 || a_rdata !== 64'h77) begin
      failures++; $display("FAIL rst_recover got gid=%0h rdy=%0h wc=%0d rdata=%0h to=%0d exp 0 1 1 77",
                           gid, rdy, wc, a_rdata, to);
    end
  endtask

  task automatic test_wrap4();
    logic [3:0] vec [4] = '{4'b0100, 4'b1010, 4'b0010, 4'b1001};
    logic [1:0] exp_rr [4] = '{2'd2, 2'd3, 2'd1, 2'd3};
    logic [1:0] exp_fp [4] = '{2'd2, 2'd1, 2'd1, 2'd0};
    logic [1:0] gid; logic [63:0] addr; logic [3:0] rdy; bit to; logic [1:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) b_addr[i*64 +: 64] = 64'h100 * 64'(i + 1);
    for (int t = 0; t < 4; t++) begin
      exp = RR ? exp_rr[t] : exp_fp[t];
      txn4(vec[t], gid, addr, rdy, to);
      checks++;
      if (to || gid !== exp || rdy !== (4'b0001 << exp) || addr !== 64'h100 * 64'(exp + 1)) begin
        failures++; $display("FAIL wrap4_%0d got gid=%0h rdy=%0h addr=%0h to=%0d exp gid=%0h rdy=%0h addr=%0h",
                             t, gid, rdy, addr, to, exp, 4'b0001 << exp, 64'h100 * 64'(exp + 1));
      end
    end
    b_valid = 4'b0000;
  endtask

  initial begin
    a_valid = '0; a_req = '0; a_addr = '0; a_wdata = '0; a_size = '0; a_mready = 1'b0; a_mrdata = '0;
    b_valid = '0; b_req = '0; b_addr = '0; b_wdata = '0; b_size = '0; b_mready = 1'b0; b_mrdata = '0;
    last_rd = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_stability();
    test_reset_mid_busy();
    test_wrap4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
